// File: rtl/master_tx_ltssm.sv
// master_tx_ltssm: transmit-side LTSSM sequencer. Picks the OS for each substate, counts framer acks, pulses txFinish.
// Optional: define MTX_EIEOS_EN to insert one EIEOS after every EIEOS_INTERVAL acked TS1s.
module master_tx_ltssm #(
   parameter int POLL_ACTIVE_MIN = 1024,
   parameter int AFTER_RX_MIN    = 16,
   parameter int EIOS_COUNT      = 1,
   parameter int EIEOS_INTERVAL  = 32,
   parameter int CNT_W           = 11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] substate,
   input  logic       rxFinish,
   input  logic       osAck,
   input  logic       detectDone,
   input  logic [2:0] trainToGen,
   input  logic [2:0] currentGen,
   output logic [2:0] osType,
   output logic       osValid,
   output logic       txElecIdle,
   output logic       padLink,
   output logic       padLane,
   output logic [1:0] ecPhase,
   output logic       speedChange,
   output logic       detectReq,
   output logic       txFinish,
   output logic [1:0] fsmState
);

   // Handshake: osType/osValid stay stable while an OS is offered; each osAck pulse
   // means the framer consumed exactly one OS. This block never stalls the framer.

   localparam logic [1:0] WAIT_S = 2'd0;
   localparam logic [1:0] SEND_S = 2'd1;
   localparam logic [1:0] DONE_S = 2'd2;

   localparam logic [2:0] OS_NONE  = 3'd0;
   localparam logic [2:0] OS_TS1   = 3'd1;
   localparam logic [2:0] OS_TS2   = 3'd2;
   localparam logic [2:0] OS_IDLE  = 3'd3;
   localparam logic [2:0] OS_EIOS  = 3'd4;

   localparam logic [CNT_W-1:0] POLL_TH  = CNT_W'(POLL_ACTIVE_MIN);
   localparam logic [CNT_W-1:0] AFTER_TH = CNT_W'(AFTER_RX_MIN);
   localparam logic [CNT_W-1:0] EIOS_TH  = CNT_W'(EIOS_COUNT);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [1:0]       st;
   logic [1:0]       stNext;
   logic [4:0]       lastState;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] cntInc;
   logic [CNT_W-1:0] cntNext;
   logic             rxSeen;
   logic             rxNext;
   logic             ackCnt;
   logic             sinceRx;
   logic             subChange;
   logic             finishNow;

`ifdef MTX_EIEOS_EN
   localparam logic [2:0]       OS_EIEOS = 3'd5;
   localparam logic [CNT_W-1:0] EIE_LAST = CNT_W'(EIEOS_INTERVAL - 1);
   logic [CNT_W-1:0] eCnt;
   logic             eiePend;
   logic             ts1Sub;

   assign ts1Sub = lastState inside {5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd11,
                                     5'd14, 5'd15, 5'd16, 5'd17};
   // An acked EIEOS is not an OS of the substate, so it never reaches count.
   assign ackCnt = osAck && !eiePend;
`else
   assign ackCnt = osAck;
`endif

   assign subChange = (substate != lastState);
   assign sinceRx   = lastState inside {5'd3, 5'd8, 5'd9, 5'd12, 5'd18};
   assign rxNext    = rxSeen | rxFinish;

   always_comb begin
      cntInc = (count == CNT_MAX) ? count : count + 1'b1;
      if (sinceRx && rxFinish)
         cntNext = ackCnt ? CNT_W'(1) : '0;
      else if (ackCnt)
         cntNext = cntInc;
      else
         cntNext = count;
   end

   always_comb begin
      finishNow = 1'b0;
      case (lastState)
         5'd0:                             finishNow = 1'b1;
         5'd1:                             finishNow = detectDone;
         5'd2:                             finishNow = rxNext && (cntNext >= POLL_TH);
         5'd3, 5'd8, 5'd9, 5'd12, 5'd18:   finishNow = rxNext && (cntNext >= AFTER_TH);
         5'd4, 5'd5, 5'd6, 5'd7, 5'd11, 5'd13,
         5'd14, 5'd15, 5'd16, 5'd17:       finishNow = rxNext;
         default:                          finishNow = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st <= WAIT_S;
      else        st <= stNext;
   end

   always_comb begin
      stNext = st;
      case (st)
         WAIT_S:  if (subChange) stNext = SEND_S;
         SEND_S: begin
            if (subChange)      stNext = WAIT_S;
            else if (finishNow) stNext = DONE_S;
         end
         DONE_S:  stNext = WAIT_S;
         default: stNext = WAIT_S;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lastState <= 5'h1F;
         count     <= '0;
         rxSeen    <= 1'b0;
         detectReq <= 1'b0;
      end else begin
         detectReq <= (st == WAIT_S) && subChange && (substate == 5'd1);
         if (st == WAIT_S && subChange) begin
            lastState <= substate;
            count     <= '0;
            rxSeen    <= 1'b0;
         end else if (st == SEND_S && !subChange) begin
            count  <= cntNext;
            rxSeen <= rxNext;
         end
      end
   end

`ifdef MTX_EIEOS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         eCnt    <= '0;
         eiePend <= 1'b0;
      end else if (st == WAIT_S && subChange) begin
         eCnt    <= '0;
         eiePend <= 1'b0;
      end else if (st == SEND_S && !subChange && osAck) begin
         if (eiePend) begin
            eiePend <= 1'b0;
         end else if (ts1Sub) begin
            if (eCnt == EIE_LAST) begin
               eCnt    <= '0;
               eiePend <= 1'b1;
            end else begin
               eCnt <= eCnt + 1'b1;
            end
         end
      end
   end
`endif

   // Fields follow lastState, so they change one cycle after a new substate and hold until the next one.
   always_comb begin
      osType      = OS_NONE;
      txElecIdle  = 1'b1;
      padLink     = 1'b1;
      padLane     = 1'b1;
      ecPhase     = 2'd0;
      speedChange = 1'b0;
      case (lastState)
         5'd2, 5'd4: begin osType = OS_TS1; txElecIdle = 1'b0; end
         5'd3:       begin osType = OS_TS2; txElecIdle = 1'b0; end
         5'd5:       begin osType = OS_TS1; txElecIdle = 1'b0; padLink = 1'b0; end
         5'd6, 5'd7: begin osType = OS_TS1; txElecIdle = 1'b0; padLink = 1'b0; padLane = 1'b0; end
         5'd8:       begin osType = OS_TS2; txElecIdle = 1'b0; padLink = 1'b0; padLane = 1'b0; end
         5'd9, 5'd10, 5'd18: begin osType = OS_IDLE; txElecIdle = 1'b0; end
         5'd11: begin
            osType = OS_TS1; txElecIdle = 1'b0; padLink = 1'b0; padLane = 1'b0;
            speedChange = (trainToGen != currentGen);
         end
         5'd12: begin
            osType = OS_TS2; txElecIdle = 1'b0; padLink = 1'b0; padLane = 1'b0;
            speedChange = (trainToGen != currentGen);
         end
         5'd13: begin
            if (count < EIOS_TH) begin osType = OS_EIOS; txElecIdle = 1'b0; end
         end
         5'd14, 5'd15, 5'd16, 5'd17: begin
            osType = OS_TS1; txElecIdle = 1'b0; padLink = 1'b0; padLane = 1'b0;
            ecPhase = lastState[1:0] + 2'd2;
         end
         default: ;
      endcase
`ifdef MTX_EIEOS_EN
      if (osType == OS_TS1 && eiePend) osType = OS_EIEOS;
`endif
      osValid  = (osType != OS_NONE);
      txFinish = (st == DONE_S);
      fsmState = st;
   end

endmodule

// File: tb/tb_master_tx_ltssm.sv
// Bench for master_tx_ltssm: behavioural model of the substate rules checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
module tb_master_tx_ltssm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] substate = 5'd2;
   logic       rxFinish = 1'b0;
   logic       osAck = 1'b0;
   logic       detectDone = 1'b0;
   logic [2:0] trainToGen = 3'd1;
   logic [2:0] currentGen = 3'd1;
   logic [2:0] osType;
   logic       osValid;
   logic       txElecIdle;
   logic       padLink;
   logic       padLane;
   logic [1:0] ecPhase;
   logic       speedChange;
   logic       detectReq;
   logic       txFinish;
   logic [1:0] fsmState;

   int checks = 0;
   int failures = 0;
   bit running = 1'b1;
   logic [2:0] exp_q[$];

   master_tx_ltssm dut (
      .clk(clk), .reset(reset), .substate(substate), .rxFinish(rxFinish), .osAck(osAck),
      .detectDone(detectDone), .trainToGen(trainToGen), .currentGen(currentGen),
      .osType(osType), .osValid(osValid), .txElecIdle(txElecIdle), .padLink(padLink),
      .padLane(padLane), .ecPhase(ecPhase), .speedChange(speedChange), .detectReq(detectReq),
      .txFinish(txFinish), .fsmState(fsmState)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   localparam int P_IDLE = 0;
   localparam int P_SEND = 1;
   localparam int P_FIN  = 2;

   int mSub = 31;
   int mPhase = P_IDLE;
   int mAcks = 0;
   int mPost = 0;
   int mTs1N = 0;
   int mEieK = 0;
   bit mRx = 1'b0;
   bit mDet = 1'b0;
   bit counted;

   function automatic bit isTs1(int s);
      return (s == 2) || (s >= 4 && s <= 7) || (s == 11) || (s >= 14 && s <= 17);
   endfunction

   function automatic bit eiePending();
`ifdef MTX_EIEOS_EN
      return isTs1(mSub) && ((mTs1N / 32) > mEieK);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit finishRule(int s, logic dd);
      if (s == 0) return 1'b1;
      if (s == 1) return dd;
      if (s == 2) return mRx && (mAcks >= 1024);
      if (s == 3 || s == 8 || s == 9 || s == 12 || s == 18) return mRx && (mPost >= 16);
      if ((s >= 4 && s <= 7) || s == 11 || (s >= 13 && s <= 17)) return mRx;
      return 1'b0;
   endfunction

   function automatic logic [2:0] expType();
      int s;
      s = mSub;
      if (isTs1(s)) return eiePending() ? 3'd5 : 3'd1;
      if (s == 3 || s == 8 || s == 12) return 3'd2;
      if (s == 9 || s == 10 || s == 18) return 3'd3;
      if (s == 13) return (mAcks < 1) ? 3'd4 : 3'd0;
      return 3'd0;
   endfunction

   function automatic bit namedLink(int s);
      return (s >= 5 && s <= 8) || s == 11 || s == 12 || (s >= 14 && s <= 17);
   endfunction

   function automatic bit namedLane(int s);
      return (s >= 6 && s <= 8) || s == 11 || s == 12 || (s >= 14 && s <= 17);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mSub = 31; mPhase = P_IDLE; mAcks = 0; mPost = 0;
         mTs1N = 0; mEieK = 0; mRx = 1'b0; mDet = 1'b0;
      end else begin
         mDet = 1'b0;
         if (mPhase == P_FIN) begin
            mPhase = P_IDLE;
         end else if (mPhase == P_IDLE) begin
            if (int'(substate) != mSub) begin
               mSub = int'(substate); mAcks = 0; mPost = 0; mTs1N = 0; mEieK = 0;
               mRx = 1'b0; mDet = (substate == 5'd1); mPhase = P_SEND;
            end
         end else if (int'(substate) != mSub) begin
            mPhase = P_IDLE;
         end else begin
            counted = osAck && !eiePending();
            if (osAck && !counted) mEieK++;
            if (counted) begin
               mAcks = (mAcks < 2047) ? mAcks + 1 : 2047;
               if (isTs1(mSub)) mTs1N++;
            end
            mPost = rxFinish ? int'(counted) : mPost + int'(counted);
            if (rxFinish) mRx = 1'b1;
            if (finishRule(mSub, detectDone)) mPhase = P_FIN;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   logic [2:0] eT;
   always @(negedge clk) begin
      if (running) begin
         eT = expType();
         chk("m_osType", osType, eT);
         chk("m_osValid", osValid, eT != 3'd0);
         chk("m_txElecIdle", txElecIdle, eT == 3'd0);
         chk("m_padLink", padLink, !namedLink(mSub));
         chk("m_padLane", padLane, !namedLane(mSub));
         chk("m_ecPhase", ecPhase, (mSub >= 14 && mSub <= 17) ? mSub - 14 : 0);
         chk("m_speedChange", speedChange, (mSub == 11 || mSub == 12) && (trainToGen != currentGen));
         chk("m_detectReq", detectReq, mDet);
         chk("m_txFinish", txFinish, mPhase == P_FIN);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input logic a, input logic r, input logic d);
      #1; osAck = a; rxFinish = r; detectDone = d;
      @(negedge clk);
   endtask

   task automatic setSub(input logic [4:0] s);
      #1; substate = s; osAck = 1'b0; rxFinish = 1'b0; detectDone = 1'b0;
      @(negedge clk);
   endtask

   task automatic setGen(input logic [2:0] tg, input logic [2:0] cg);
      #1; trainToGen = tg; currentGen = cg;
   endtask

   task automatic chkResetVals(input string tag);
      chk({tag, "_osType"}, osType, 3'd0);
      chk({tag, "_osValid"}, osValid, 1'b0);
      chk({tag, "_txElecIdle"}, txElecIdle, 1'b1);
      chk({tag, "_padLink"}, padLink, 1'b1);
      chk({tag, "_padLane"}, padLane, 1'b1);
      chk({tag, "_ecPhase"}, ecPhase, 2'd0);
      chk({tag, "_speedChange"}, speedChange, 1'b0);
      chk({tag, "_detectReq"}, detectReq, 1'b0);
      chk({tag, "_txFinish"}, txFinish, 1'b0);
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   int eieSeen;
   int s;
   int len;
   initial begin
      // reset values
      @(negedge clk); @(negedge clk);
      chkResetVals("rst");
      #1 reset = 1'b1;
      @(negedge clk);
      chk("poll_osType", osType, 3'd1);
      chk("poll_pads", {padLink, padLane}, 2'b11);

      // reset in the middle of pollingActive, then a full pollingActive run from zero
      for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
      #1 reset = 1'b0; osAck = 1'b0;
      @(negedge clk);
      chkResetVals("midrst");
      #1 reset = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 1024; i++) begin
         step(1'b1, i == 500, 1'b0);
         if (i == 1023) chk("poll_noFinish_1023", txFinish, 1'b0);
         if (i == 1024) begin
            chk("poll_finish_1024", txFinish, 1'b1);
            chk("poll_finish_osType", osType, 3'd1);
         end
      end
      step(1'b0, 1'b0, 1'b0);
      chk("poll_finish_single", txFinish, 1'b0);

      // cfgComplete: 16 acks counted from the rxFinish cycle
      setSub(5'd8);
      chk("cfgc_osType", osType, 3'd2);
      chk("cfgc_pads", {padLink, padLane}, 2'b00);
      for (int i = 1; i <= 18; i++) begin
         step(1'b1, i == 3, 1'b0);
         if (i == 17) chk("cfgc_noFinish_17", txFinish, 1'b0);
         if (i == 18) chk("cfgc_finish_18", txFinish, 1'b1);
      end
      step(1'b0, 1'b0, 1'b0);

      // rcvrCfg with speed change, aborted into recoverySpeed
      setGen(3'd3, 3'd1);
      setSub(5'd12);
      chk("rcfg_speedChange", speedChange, 1'b1);
      chk("rcfg_osType", osType, 3'd2);
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, i == 2, 1'b0);
         chk("rcfg_noFinish", txFinish, 1'b0);
      end
      setSub(5'd13);
      chk("abort_noFinish", txFinish, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("rspd_osType_eios", osType, 3'd4);
      chk("rspd_elecIdle0", txElecIdle, 1'b0);
      chk("rspd_speedChange", speedChange, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("rspd_osType_none", osType, 3'd0);
      chk("rspd_elecIdle1", txElecIdle, 1'b1);
      chk("rspd_noFinish", txFinish, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("rspd_finish", txFinish, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // equalization phase 1
      setSub(5'd15);
      chk("ph1_osType", osType, 3'd1);
      chk("ph1_ecPhase", ecPhase, 2'd1);
      step(1'b0, 1'b1, 1'b0);
      chk("ph1_finish", txFinish, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // detectActive
      setSub(5'd1);
      chk("det_req", detectReq, 1'b1);
      chk("det_idle", txElecIdle, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      chk("det_req_pulse", detectReq, 1'b0);
      chk("det_wait", txFinish, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("det_finish", txFinish, 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // rcvrLock with continuous acks: EIEOS every 33rd presentation only when enabled
      for (int k = 1; k <= 100; k++) begin
`ifdef MTX_EIEOS_EN
         exp_q.push_back((k % 33 == 0) ? 3'd5 : 3'd1);
`else
         exp_q.push_back(3'd1);
`endif
      end
      eieSeen = 0;
      setSub(5'd11);
      for (int k = 1; k <= 100; k++) begin
         chk("lock_osType", osType, exp_q.pop_front());
         if (osType == 3'd5) eieSeen++;
         step(1'b1, 1'b0, 1'b0);
      end
`ifdef MTX_EIEOS_EN
      chk("lock_eieos_count", eieSeen, 3);
`else
      chk("lock_eieos_count", eieSeen, 0);
`endif

      // randomized substate visits
      for (int v = 0; v < 160; v++) begin
         s = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 18) : $urandom_range(19, 31);
         if ($urandom_range(0, 39) == 0) begin
            #1 reset = 1'b0;
            @(negedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
         end
         if ($urandom_range(0, 3) == 0)
            setGen(3'($urandom_range(1, 5)), 3'($urandom_range(1, 5)));
         setSub(s[4:0]);
         len = $urandom_range(3, 50);
         for (int c = 0; c < len; c++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
      end

      running = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
